// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, parity modes and frame limits.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BREAK
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [3:0] MIN_BITS = 4'd5;

    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Rx line synchroniser plus a two-deep history of Tick-strobed samples; vote is the
// 2-of-3 majority of the two previous Tick samples and the current synchronised level.
module uart_rx_sync #(
    parameter int SYNC_FF = 2
) (
    input  logic Clk,
    input  logic rst,
    input  logic Tick,
    input  logic Rx,
    output logic rxs,
    output logic vote
);

    logic [SYNC_FF-1:0] sync_q;
    logic [1:0]         hist_q;

    // Preset to idle-high so reset never looks like a start bit.
    always_ff @(posedge Clk) begin
        if (rst) begin
            sync_q <= '1;
            hist_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[SYNC_FF-2:0], Rx};
            if (Tick) begin
                hist_q <= {hist_q[0], rxs};
            end
        end
    end

    assign rxs  = sync_q[SYNC_FF-1];
    assign vote = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled deframing of start/data/parity/stop with
// majority voting, break handling and a one-entry valid/ready output register.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int OVS       = 16,
    parameter int SYNC_FF   = 2
) (
    input  logic                 Clk,
    input  logic                 rst,
    input  logic                 Tick,
    input  logic                 RxEn,
    input  logic                 Rx,
    input  logic [3:0]           NBits,
    input  logic [1:0]           ParityMode,
    input  logic                 StopBits,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 RxValid,
    input  logic                 RxReady,
    output logic                 FrameErr,
    output logic                 ParityErr,
    output logic                 OverrunErr,
    output logic                 Busy
);

    localparam int            CW       = $clog2(OVS);
    // Decision tick: third of the three centre samples (OVS/2-1, OVS/2, OVS/2+1).
    localparam logic [CW-1:0] MID      = CW'(OVS / 2 + 1);
    localparam logic [CW-1:0] LAST     = CW'(OVS - 1);
    localparam logic [3:0]    MAX_BITS = 4'(DATA_BITS);

    uart_state_t          state, state_nxt;
    logic                 rxs, vote;
    logic [CW-1:0]        tick_cnt;
    logic [3:0]           bit_cnt, nbits_q;
    logic [1:0]           pmode_q;
    logic                 stop2_q;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc, perr_q, ferr_q, done_q;
    logic                 samp, confirm, word_done, last_bit;

    function automatic logic [3:0] clamp_bits(input logic [3:0] n);
        if (n < MIN_BITS) return MIN_BITS;
        if (n > MAX_BITS) return MAX_BITS;
        return n;
    endfunction

    uart_rx_sync #(.SYNC_FF(SYNC_FF)) u_sync (
        .Clk  (Clk),
        .rst  (rst),
        .Tick (Tick),
        .Rx   (Rx),
        .rxs  (rxs),
        .vote (vote)
    );

    // After start confirm the counter restarts at 0, so every later bit decides at LAST,
    // which lands on the same centre-plus-one tick of each bit period.
    assign samp     = Tick && (tick_cnt == ((state == ST_START) ? MID : LAST));
    assign last_bit = (bit_cnt == nbits_q - 4'd1);
    assign Busy     = (state != ST_IDLE);

    always_ff @(posedge Clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        confirm   = 1'b0;
        word_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (RxEn && !rxs) state_nxt = ST_START;
            end
            ST_START: begin
                if (samp) begin
                    if (vote) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        confirm   = 1'b1;
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (samp && last_bit) begin
                    state_nxt = par_enabled(pmode_q) ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                if (samp) state_nxt = ST_STOP1;
            end
            ST_STOP1: begin
                if (samp) begin
                    if (stop2_q) begin
                        state_nxt = ST_STOP2;
                    end else begin
                        word_done = 1'b1;
                        state_nxt = (ferr_q || !vote) ? ST_BREAK : ST_IDLE;
                    end
                end
            end
            ST_STOP2: begin
                if (samp) begin
                    word_done = 1'b1;
                    state_nxt = (ferr_q || !vote) ? ST_BREAK : ST_IDLE;
                end
            end
            ST_BREAK: begin
                if (rxs) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            nbits_q  <= '0;
            pmode_q  <= PAR_NONE;
            stop2_q  <= 1'b0;
            par_acc  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= word_done;
            if (state == ST_IDLE) begin
                tick_cnt <= '0;
            end else if (Tick) begin
                tick_cnt <= samp ? '0 : tick_cnt + 1'b1;
            end
            if (confirm) begin
                nbits_q <= clamp_bits(NBits);
                pmode_q <= ParityMode;
                stop2_q <= StopBits;
                bit_cnt <= '0;
                par_acc <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
            end
            if (samp && state == ST_DATA) begin
                bit_cnt <= bit_cnt + 4'd1;
                par_acc <= par_acc ^ vote;
            end
            // Odd parity wants the total XOR to be 1, so folding the mode in flags the mismatch.
            if (samp && state == ST_PARITY) begin
                perr_q <= par_acc ^ vote ^ (pmode_q == PAR_ODD);
            end
            if (samp && (state == ST_STOP1 || state == ST_STOP2) && !vote) begin
                ferr_q <= 1'b1;
            end
        end
    end

    // Bits land at their final index so short words come out right-justified.
    always_ff @(posedge Clk) begin
        if (confirm) begin
            shreg <= '0;
        end else if (samp && state == ST_DATA) begin
            for (int i = 0; i < DATA_BITS; i++) begin
                if (bit_cnt == 4'(i)) shreg[i] <= vote;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            RxData     <= '0;
            RxValid    <= 1'b0;
            FrameErr   <= 1'b0;
            ParityErr  <= 1'b0;
            OverrunErr <= 1'b0;
        end else begin
            OverrunErr <= 1'b0;
            if (done_q) begin
                if (!RxValid || RxReady) begin
                    RxData    <= shreg;
                    FrameErr  <= ferr_q;
                    ParityErr <= perr_q;
                    RxValid   <= 1'b1;
                end else begin
                    OverrunErr <= 1'b1;
                end
            end else if (RxValid && RxReady) begin
                RxValid <= 1'b0;
            end
        end
    end

endmodule
